// File: rtl/lemon_rf_pkg.sv
// rtl/lemon_rf_pkg.sv - shared types, default widths and bypass winner select for the LemonPC register file
package lemon_rf_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  localparam int RF_AW     = 5;
  localparam int RF_DW     = 32;
  localparam int RF_MAX_NW = 2;

  // Highest-numbered matching write port wins; -1 when no port matches.
  function automatic int rf_bypass_sel(input logic [RF_MAX_NW-1:0] hit);
    int sel;
    sel = -1;
    for (int j = 0; j < RF_MAX_NW; j++) begin
      if (hit[j]) sel = j;
    end
    return sel;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending-write bits with set-over-clear priority and rs_busy lookup
module regfile_scoreboard
  import lemon_rf_pkg::*;
#(
  parameter int AW = RF_AW,
  parameter int NW = 1,
  parameter int NR = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             active,
  input  logic [NW-1:0]    wen,
  input  logic [NW*AW-1:0] wd_addr,
  input  logic             sb_set,
  input  logic [AW-1:0]    sb_rd,
  input  logic [NR*AW-1:0] rs_addr,
  output logic [NR-1:0]    rs_busy
);

  logic [2**AW-1:0] busy;

  // Later non-blocking assignments take precedence: clears first, then the newer reservation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else if (active) begin
      for (int j = 0; j < NW; j++) begin
        if (wen[j]) busy[wd_addr[j*AW +: AW]] <= 1'b0;
      end
      if (sb_set) busy[sb_rd] <= 1'b1;
      busy[0] <= 1'b0;
    end
  end

  always_comb begin
    rs_busy = '0;
    for (int i = 0; i < NR; i++) begin
      rs_busy[i] = active & busy[rs_addr[i*AW +: AW]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with x0 hardwired, optional bypass, scoreboard and post-reset clear sweep
// Optional REGFILE_TRACE_EN adds a simulation-only change trace of the array.
module regfile_mp
  import lemon_rf_pkg::*;
#(
  parameter int AW     = RF_AW,
  parameter int DW     = RF_DW,
  parameter int NR     = 2,
  parameter int NW     = 1,
  parameter int BYPASS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NR*AW-1:0] rs_addr,
  output logic [NR*DW-1:0] rs_data,
  output logic [NR-1:0]    rs_busy,
  input  logic [NW-1:0]    wen,
  input  logic [NW*AW-1:0] wd_addr,
  input  logic [NW*DW-1:0] wd_data,
  input  logic             sb_set,
  input  logic [AW-1:0]    sb_rd,
  output logic             ready
);

  rf_state_e     state;
  logic [AW-1:0] cnt;
  logic [DW-1:0] rf [2**AW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RF_CLEAR;
      cnt   <= AW'(1);
      ready <= 1'b0;
    end else if (state == RF_CLEAR) begin
      if (cnt == '1) begin
        state <= RF_READY;
        ready <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Ascending port order makes the highest-numbered port win a same-address collision.
  always_ff @(posedge clk) begin
    if (state == RF_CLEAR) begin
      rf[cnt] <= '0;
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (wen[j] && wd_addr[j*AW +: AW] != '0)
          rf[wd_addr[j*AW +: AW]] <= wd_data[j*DW +: DW];
      end
    end
  end

  for (genvar i = 0; i < NR; i++) begin : g_rd
    logic [AW-1:0]        ra;
    logic [RF_MAX_NW-1:0] hit;
    logic [DW-1:0]        rd;
    int                   bsel;

    assign ra = rs_addr[i*AW +: AW];

    always_comb begin
      hit = '0;
      for (int j = 0; j < NW; j++) begin
        hit[j] = wen[j] && (wd_addr[j*AW +: AW] == ra);
      end
      bsel = rf_bypass_sel(hit);
      rd   = '0;
      if (state == RF_READY && ra != '0) begin
        if (BYPASS != 0 && bsel >= 0) rd = wd_data[bsel*DW +: DW];
        else                          rd = rf[ra];
      end
    end

    assign rs_data[i*DW +: DW] = rd;
  end

  regfile_scoreboard #(
    .AW (AW),
    .NW (NW),
    .NR (NR)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .active  (ready),
    .wen     (wen),
    .wd_addr (wd_addr),
    .sb_set  (sb_set),
    .sb_rd   (sb_rd),
    .rs_addr (rs_addr),
    .rs_busy (rs_busy)
  );

`ifdef REGFILE_TRACE_EN
  logic [DW-1:0] shadow [2**AW];

  always @(posedge clk) begin : trace
    bit later;
    if (state == RF_CLEAR) begin
      shadow[cnt] <= '0;
    end else begin
      for (int j = 0; j < NW; j++) begin
        later = 1'b0;
        for (int k = j + 1; k < NW; k++) begin
          if (wen[k] && wd_addr[k*AW +: AW] == wd_addr[j*AW +: AW]) later = 1'b1;
        end
        if (wen[j] && wd_addr[j*AW +: AW] != '0 && !later) begin
          if (shadow[wd_addr[j*AW +: AW]] !== wd_data[j*DW +: DW])
            $display("x%0d changed, from 0x%h(%0d) to 0x%h(%0d)",
                     wd_addr[j*AW +: AW],
                     shadow[wd_addr[j*AW +: AW]], $signed(shadow[wd_addr[j*AW +: AW]]),
                     wd_data[j*DW +: DW], $signed(wd_data[j*DW +: DW]));
          shadow[wd_addr[j*AW +: AW]] <= wd_data[j*DW +: DW];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed checks of regfile_mp: a two-write-port bypass build and a one-port no-bypass build
module tb_regfile_mp;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR*AW-1:0] rs_addr;
  logic [NR*DW-1:0] rs_data_a, rs_data_b;
  logic [NR-1:0]    rs_busy_a, rs_busy_b;
  logic [1:0]       wen;
  logic [2*AW-1:0]  wd_addr;
  logic [2*DW-1:0]  wd_data;
  logic             sb_set;
  logic [AW-1:0]    sb_rd;
  logic             ready_a, ready_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  regfile_mp #(.AW(AW), .DW(DW), .NR(NR), .NW(2), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rs_data_a), .rs_busy(rs_busy_a),
    .wen(wen), .wd_addr(wd_addr), .wd_data(wd_data),
    .sb_set(sb_set), .sb_rd(sb_rd), .ready(ready_a)
  );

  regfile_mp #(.AW(AW), .DW(DW), .NR(NR), .NW(1), .BYPASS(0)) u_dut_nb (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rs_data_b), .rs_busy(rs_busy_b),
    .wen(wen[0]), .wd_addr(wd_addr[AW-1:0]), .wd_data(wd_data[DW-1:0]),
    .sb_set(sb_set), .sb_rd(sb_rd), .ready(ready_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen    = '0;
    sb_set = 1'b0;
    sb_rd  = '0;
  endtask

  task automatic sweep(input string tag);
    int n;
    bit bad;
    n   = 0;
    bad = 1'b0;
    while (!ready_a && n < 100) begin
      if (rs_data_a !== '0 || rs_data_b !== '0 || rs_busy_a !== '0) bad = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, " edges to ready"}, 64'(n), 64'd31);
    chk({tag, " nb ready"}, 64'(ready_b), 64'd1);
    chk({tag, " zero during sweep"}, 64'(bad), 64'd0);
  endtask

  initial begin
    rs_addr = '0;
    wd_addr = '0;
    wd_data = '0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready", 64'(ready_a), 64'd0);
    chk("reset busy", 64'(rs_busy_a), 64'd0);

    // 1: sweep with writes and reservations that must be ignored
    rst     = 1'b0;
    wen     = 2'b11;
    wd_addr = {5'd6, 5'd5};
    wd_data = {32'hAAAA5555, 32'hFFFFFFFF};
    sb_set  = 1'b1;
    sb_rd   = 5'd6;
    rs_addr = {5'd6, 5'd5};
    sweep("t1");
    idle();
    #1;
    chk("t1 x5 after sweep", 64'(rs_data_a[31:0]), 64'd0);
    chk("t1 x6 after sweep", 64'(rs_data_a[63:32]), 64'd0);
    chk("t1 x6 not busy", 64'(rs_busy_a), 64'd0);

    // 2: plain write and read-back, x0 stays zero
    wen     = 2'b01;
    wd_addr = {5'd0, 5'd5};
    wd_data = {32'h0, 32'hDEADBEEF};
    rs_addr = {5'd6, 5'd6};
    step();
    idle();
    rs_addr = {5'd5, 5'd5};
    #1;
    chk("t2 x5 p0", 64'(rs_data_a[31:0]), 64'hDEADBEEF);
    chk("t2 x5 p1", 64'(rs_data_a[63:32]), 64'hDEADBEEF);
    chk("t2 x5 nb", 64'(rs_data_b[31:0]), 64'hDEADBEEF);
    wen     = 2'b01;
    wd_addr = {5'd0, 5'd0};
    wd_data = {32'h0, 32'h1234};
    rs_addr = {5'd0, 5'd0};
    #1;
    chk("t2 x0 no bypass", 64'(rs_data_a[31:0]), 64'd0);
    step();
    idle();
    #1;
    chk("t2 x0 after write", 64'(rs_data_a[31:0]), 64'd0);

    // 3: same-cycle bypass vs. registered read
    wen     = 2'b01;
    wd_addr = {5'd0, 5'd7};
    wd_data = {32'h0, 32'h55};
    rs_addr = {5'd7, 5'd7};
    #1;
    chk("t3 bypass x7", 64'(rs_data_a[31:0]), 64'h55);
    chk("t3 nobypass x7 old", 64'(rs_data_b[31:0]), 64'd0);
    step();
    idle();
    #1;
    chk("t3 nobypass x7 new", 64'(rs_data_b[31:0]), 64'h55);

    // 4: both write ports hit x9, port 1 wins
    wen     = 2'b11;
    wd_addr = {5'd9, 5'd9};
    wd_data = {32'h22, 32'h11};
    rs_addr = {5'd9, 5'd9};
    #1;
    chk("t4 bypass p1", 64'(rs_data_a[63:32]), 64'h22);
    chk("t4 bypass p0", 64'(rs_data_a[31:0]), 64'h22);
    step();
    idle();
    #1;
    chk("t4 x9 array", 64'(rs_data_a[31:0]), 64'h22);
    chk("t4 x9 nb", 64'(rs_data_b[31:0]), 64'h11);

    // 5: scoreboard set/clear priority
    rs_addr = {5'd3, 5'd3};
    sb_set  = 1'b1;
    sb_rd   = 5'd3;
    #1;
    chk("t5 busy pre-edge", 64'(rs_busy_a), 64'd0);
    step();
    idle();
    #1;
    chk("t5 busy after set", 64'(rs_busy_a), 64'b11);
    wen     = 2'b01;
    wd_addr = {5'd0, 5'd3};
    wd_data = {32'h0, 32'h1};
    sb_set  = 1'b1;
    sb_rd   = 5'd3;
    step();
    idle();
    #1;
    chk("t5 set beats clear", 64'(rs_busy_a), 64'b11);
    wen     = 2'b01;
    wd_addr = {5'd0, 5'd3};
    step();
    idle();
    #1;
    chk("t5 write clears", 64'(rs_busy_a), 64'b00);
    sb_set  = 1'b1;
    sb_rd   = 5'd4;
    step();
    idle();
    wen     = 2'b10;
    wd_addr = {5'd4, 5'd0};
    rs_addr = {5'd4, 5'd4};
    #1;
    chk("t5 x4 busy", 64'(rs_busy_a), 64'b11);
    step();
    idle();
    #1;
    chk("t5 port1 clears", 64'(rs_busy_a), 64'b00);
    rs_addr = {5'd0, 5'd0};
    sb_set  = 1'b1;
    sb_rd   = 5'd0;
    step();
    idle();
    #1;
    chk("t5 x0 never busy", 64'(rs_busy_a), 64'b00);

    // 6: reset while READY with x3 busy
    sb_set = 1'b1;
    sb_rd  = 5'd3;
    step();
    idle();
    rs_addr = {5'd5, 5'd3};
    #1;
    chk("t6 x3 busy", 64'(rs_busy_a[0]), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6 ready drops", 64'(ready_a), 64'd0);
    chk("t6 busy drops", 64'(rs_busy_a), 64'd0);
    chk("t6 read zero", 64'(rs_data_a), 64'd0);
    step();
    step();
    rst = 1'b0;
    sweep("t6");
    #1;
    chk("t6 x5 cleared", 64'(rs_data_a[63:32]), 64'd0);
    chk("t6 x3 free", 64'(rs_busy_a[0]), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
